// File: rtl/addon_pkg.sv
// rtl/addon_pkg.sv - shared types and constants for the addon adder scheduler
package addon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int ADDON_WIDTH = 8;

    // Result-ID width: enough bits to name every requester, never less than one.
    function automatic int id_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/addon_rr_arbiter.sv
// rtl/addon_rr_arbiter.sv - combinational round-robin grant over a request vector
module addon_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    int   cand;
    logic found;

    // Search starts just after the last winner and takes the first active request.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/addon_share_ctrl.sv
// rtl/addon_share_ctrl.sv - time-shares one adder among several valid/ready requesters
module addon_share_ctrl
    import addon_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int WIDTH = ADDON_WIDTH,
    parameter int IDW   = id_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res_sum,
    output logic                  res_carry,
    output logic [IDW-1:0]        res_id,
    output logic                  busy
);

    state_t           state;
    logic [IDW-1:0]   ptr;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDW-1:0]   id_q;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             accept;

    addon_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx)
    );

    // Grants are only offered while idle; reset silences them immediately.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && !rst) begin
            req_ready = grant;
        end
    end

    assign accept = |(req_valid & req_ready);

    // Route the granted requester's operands toward the operand registers.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Accept -> add -> present result, holding the result until it is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= IDW'(NREQ - 1);
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= '0;
            res_sum   <= '0;
            res_carry <= 1'b0;
            res_id    <= '0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q   <= sel_a;
                        b_q   <= sel_b;
                        id_q  <= grant_idx;
                        ptr   <= grant_idx;
                        busy  <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    {res_carry, res_sum} <= {1'b0, a_q} + {1'b0, b_q};
                    res_id    <= id_q;
                    res_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addon_share_ctrl.sv
// tb/tb_addon_share_ctrl.sv - self-checking bench for addon_share_ctrl
module tb_addon_share_ctrl;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*W-1:0] req_a = '0;
    logic [NREQ*W-1:0] req_b = '0;
    logic [NREQ-1:0]   req_ready;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [W-1:0]      res_sum;
    logic              res_carry;
    logic [IDW-1:0]    res_id;
    logic              busy;

    int total = 0;
    int bad   = 0;

    addon_share_ctrl #(
        .NREQ  (NREQ),
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_carry (res_carry),
        .res_id    (res_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*W +: W] = W'(a);
        req_b[i*W +: W] = W'(b);
    endtask

    // Reference model: last winner, cycles since the last accept, expected result.
    int m_ptr = NREQ - 1;
    int m_age = -1;
    int m_sum, m_carry, m_id, m_pick, m_tot;
    logic [NREQ-1:0] m_exp;

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            m_ptr = NREQ - 1;
            m_age = -1;
            chk("rst_req_ready", req_ready, 0);
            chk("rst_res_valid", res_valid, 0);
            chk("rst_res_sum", res_sum, 0);
            chk("rst_res_carry", res_carry, 0);
            chk("rst_res_id", res_id, 0);
            chk("rst_busy", busy, 0);
        end else begin
            m_pick = (m_age < 0) ? rr_pick(req_valid, m_ptr) : -1;
            m_exp  = '0;
            if (m_pick >= 0) m_exp[m_pick] = 1'b1;
            chk("req_ready", req_ready, m_exp);
            chk("ready_onehot", $onehot0(req_ready), 1);
            chk("res_valid", res_valid, m_age == 1);
            chk("busy", busy, m_age >= 0);
            if (m_age == 1) begin
                chk("res_sum", res_sum, m_sum);
                chk("res_carry", res_carry, m_carry);
                chk("res_id", res_id, m_id);
            end
            if (m_pick >= 0) begin
                m_tot   = int'(req_a[m_pick*W +: W]) + int'(req_b[m_pick*W +: W]);
                m_sum   = m_tot % (1 << W);
                m_carry = m_tot / (1 << W);
                m_id    = m_pick;
                m_ptr   = m_pick;
                m_age   = 0;
            end else if (m_age == 0) begin
                m_age = 1;
            end else if (m_age == 1 && res_ready) begin
                m_age = -1;
            end
        end
    end

    int g_idx[$];
    int g_cyc[$];
    int r_id[$];
    int r_sum[$];
    logic [NREQ-1:0] acc;

    initial begin
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Single request from requester 0.
        set_op(0, 20, 99);
        req_valid = 4'b0001;
        res_ready = 1'b1;
        #2 chk("t1_ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        step();
        #2;
        chk("t1_valid", res_valid, 1);
        chk("t1_sum", res_sum, 119);
        chk("t1_carry", res_carry, 0);
        chk("t1_id", res_id, 0);
        step();
        #2 chk("t1_busy_low", busy, 0);

        // Overflowing addition from requester 1.
        set_op(1, 200, 100);
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        step();
        #2;
        chk("t2_sum", res_sum, 44);
        chk("t2_carry", res_carry, 1);
        chk("t2_id", res_id, 1);
        step();

        // Two requesters held valid: grants alternate, 3 cycles apart.
        set_op(0, 1, 2);
        set_op(1, 3, 4);
        req_valid = 4'b0011;
        for (int c = 0; c < 12; c++) begin
            #2;
            if (req_ready != 0) begin
                g_idx.push_back(req_ready[1] ? 1 : 0);
                g_cyc.push_back(c);
            end
            step();
        end
        req_valid = '0;
        chk("t3_count", g_idx.size(), 4);
        for (int i = 0; i < 4 && i < g_idx.size(); i++) begin
            chk("t3_order", g_idx[i], i % 2);
            chk("t3_spacing", g_cyc[i], 3 * i);
        end

        // Backpressure holds the result and starves the waiting requester.
        set_op(0, 50, 50);
        set_op(1, 7, 8);
        req_valid = 4'b0011;
        res_ready = 1'b0;
        #2 chk("t4_ready0", req_ready, 4'b0001);
        step();
        req_valid = 4'b0010;
        step();
        step();
        for (int c = 0; c < 5; c++) begin
            #2;
            chk("t4_hold_valid", res_valid, 1);
            chk("t4_hold_sum", res_sum, 100);
            chk("t4_no_grant", req_ready, 0);
            step();
        end
        res_ready = 1'b1;
        #2 chk("t4_hs_no_grant", req_ready, 0);
        step();
        #2 chk("t4_then_req1", req_ready, 4'b0010);
        step();
        req_valid = '0;
        step();
        step();
        step();

        // Reset while a result is presented.
        set_op(1, 1, 1);
        req_valid = 4'b0010;
        res_ready = 1'b0;
        step();
        req_valid = '0;
        step();
        step();
        #2 chk("t5_in_resp", res_valid, 1);
        rst = 1'b1;
        #1;
        chk("t5_valid0", res_valid, 0);
        chk("t5_sum0", res_sum, 0);
        chk("t5_busy0", busy, 0);
        chk("t5_ready0", req_ready, 0);
        req_valid = 4'b0011;
        step();
        rst = 1'b0;
        #2 chk("t5_req0_first", req_ready, 4'b0001);
        step();
        req_valid = '0;
        res_ready = 1'b1;
        step();
        step();
        step();

        // All four requesters valid after a fresh reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_op(i, i + 1, 2 * (i + 1));
        req_valid = '1;
        for (int c = 0; c < 14; c++) begin
            #2;
            if (res_valid && res_ready) begin
                r_id.push_back(int'(res_id));
                r_sum.push_back(int'(res_sum));
            end
            step();
        end
        req_valid = '0;
        step();
        step();
        step();
        chk("t6_count", r_id.size(), 4);
        for (int i = 0; i < 4 && i < r_id.size(); i++) begin
            chk("t6_id", r_id[i], i);
            chk("t6_sum", r_sum[i], 3 * (i + 1));
        end

        // Randomized traffic with backpressure, drops and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            #2;
            acc = req_valid & req_ready;
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i] || !req_valid[i]) begin
                    req_valid[i] = ($urandom % 3) == 0;
                    set_op(i, ($urandom % 4 == 0) ? 255 : int'($urandom % 256),
                              ($urandom % 4 == 0) ? 255 : int'($urandom % 256));
                end else if ($urandom % 40 == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            res_ready = ($urandom % 3) != 0;
            rst = ($urandom % 400) == 0;
        end
        rst = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
